// File: rtl/alu_seq.sv
// Registered, handshaked ALU: ADD/XOR/SUB with {N,Z,C,V} flags, one operation in flight.
// Define ALU_MUL_EN to build op 11 as a WIDTH-cycle shift-add multiplier; otherwise op 11 reports op_err.
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] ALU_in1,
    input  logic [WIDTH-1:0] ALU_in2,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_out,
    output logic [3:0]       flags,
    output logic             op_err,
    output logic [1:0]       state_dbg
);

    // Handshake: a transfer happens on any rising edge where valid and ready are both high;
    // in_ready is high only in IDLE, out_valid only in DONE, and DONE outputs hold until out_ready.

    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       op_q;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] exec_res;
    logic             exec_c;
    logic             exec_v;
    logic             exec_err;
    logic [3:0]       exec_flags;

    assign state_dbg = state;

    assign sum  = {1'b0, a_q} + {1'b0, b_q};
    assign diff = {1'b0, a_q} + {1'b0, ~b_q} + (WIDTH+1)'(1);

    always_comb begin
        exec_res = '0;
        exec_c   = 1'b0;
        exec_v   = 1'b0;
        exec_err = 1'b0;
        case (op_q)
            2'b00: begin
                {exec_c, exec_res} = sum;
                exec_v = (a_q[MSB] == b_q[MSB]) && (sum[MSB] != a_q[MSB]);
            end
            2'b01: exec_res = a_q ^ b_q;
            2'b10: begin
                {exec_c, exec_res} = diff;
                exec_v = (a_q[MSB] != b_q[MSB]) && (diff[MSB] != a_q[MSB]);
            end
            default: exec_err = 1'b1;
        endcase
        // An unsupported op reports all-zero flags, so Z stays clear despite R=0.
        exec_flags = exec_err ? 4'b0000 : {exec_res[MSB], (exec_res == '0), exec_c, exec_v};
    end

`ifdef ALU_MUL_EN
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   count;

    assign acc_next = acc + (mplier[0] ? mcand : '0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            ALU_out   <= '0;
            flags     <= 4'b0000;
            op_err    <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= 2'b00;
`ifdef ALU_MUL_EN
            mcand     <= '0;
            acc       <= '0;
            mplier    <= '0;
            count     <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q      <= ALU_in1;
                        b_q      <= ALU_in2;
                        op_q     <= op;
                        in_ready <= 1'b0;
                        state    <= S_EXEC;
`ifdef ALU_MUL_EN
                        if (op == 2'b11) begin
                            state  <= S_MUL;
                            mcand  <= {{WIDTH{1'b0}}, ALU_in1};
                            mplier <= ALU_in2;
                            acc    <= '0;
                            count  <= '0;
                        end
`endif
                    end
                end
                S_EXEC: begin
                    ALU_out   <= exec_res;
                    flags     <= exec_flags;
                    op_err    <= exec_err;
                    out_valid <= 1'b1;
                    state     <= S_DONE;
                end
`ifdef ALU_MUL_EN
                S_MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + CNT_W'(1);
                    // The final partial product is folded in combinationally so DONE follows the last iteration.
                    if (count == LAST) begin
                        ALU_out   <= acc_next[WIDTH-1:0];
                        flags     <= {acc_next[MSB], (acc_next[WIDTH-1:0] == '0),
                                      (acc_next[2*WIDTH-1:WIDTH] != '0), 1'b0};
                        op_err    <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
